mem_port_arbiter: RTL and testbench

- Shares the single external memory bus between the instruction-fetch requester (inst) and the MEM-stage data requester (data).
- Latches one request at a time, drives it on the bus, and routes the response back to its owner.
- Data has priority because the MEM stage is older; a starvation counter guarantees fetch progress.
- Sits between the pipeline (IF/MEM stages) and the bus bridge.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory bus arbiter: shares one external bus between instruction fetch
// and MEM-stage data accesses, one outstanding transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_wr_q, bus_wr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    logic in_idle;
    logic inst_forced;
    logic grant_data;
    logic grant_inst;
    logic done;

    // Grant decision and completion detect; reset masks every handshake
    always_comb begin
        in_idle     = (state_q == S_IDLE) && !rst;
        inst_forced = inst_req && (starve_cnt_q == CNT_MAX);
        grant_data  = in_idle && data_req && !inst_forced;
        grant_inst  = in_idle && inst_req && !grant_data;
        done        = !rst &&
                      (((state_q == S_ADDR) && bus_addr_ok && bus_data_ok) ||
                       ((state_q == S_WAIT) && bus_data_ok));
    end

    // Next-state, request latch and starvation counter
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d     = S_ADDR;
                    owner_d     = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_wr;
                    bus_size_d  = data_size;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                    if (!inst_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CNT_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (grant_inst) begin
                    state_d      = S_ADDR;
                    owner_d      = 1'b0;
                    bus_req_d    = 1'b1;
                    bus_wr_d     = 1'b0;
                    bus_size_d   = 2'd2;
                    bus_addr_d   = inst_addr;
                    starve_cnt_d = '0;
                end
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    state_d   = bus_data_ok ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = done && !owner_q;
    assign data_data_ok = done && owner_q;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;

    // reference model: transaction phase 0 none, 1 address, 2 waiting data
    int          phase = 0;
    int          streak = 0;
    bit          m_owner;
    bit          m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    int          ad_cnt, wd_cnt;
    bit          same_cyc;

    // bus responder knobs (-1 = random)
    int          f_ad = -1, f_same = -1, f_wd = -1;
    bit          f_rd_en = 0;
    logic [31:0] f_rd = '0;
    bit          noise = 0, stale_bd = 0, keep_data = 0;

    // observation logs
    int          g_cyc[$];
    bit          g_own[$];
    int          d_cyc[$];
    bit          d_own[$];
    logic [31:0] d_rd[$];
    int          br_cyc[$];
    logic        a_wr;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        g_cyc.delete(); g_own.delete();
        d_cyc.delete(); d_own.delete(); d_rd.delete();
        br_cyc.delete();
    endtask

    task automatic tick();
        logic ba, bd, gi, gd, dn;
        logic [31:0] rd;
        ba = 1'b0;
        bd = 1'b0;
        rd = f_rd_en ? f_rd : $urandom;
        if (phase == 1) begin
            if (ad_cnt == 0) begin
                ba = 1'b1;
                bd = same_cyc;
            end
        end else if (phase == 2) begin
            bd = (wd_cnt == 0);
        end else begin
            bd = stale_bd || (noise && $urandom_range(0, 3) == 0);
        end
        bus_addr_ok = ba;
        bus_data_ok = bd;
        bus_rdata   = rd;
        @(negedge clk);
        gi = 1'b0;
        gd = 1'b0;
        dn = 1'b0;
        if (!rst) begin
            if (phase == 0) begin
                gd = data_req && !(inst_req && streak == LIM);
                gi = inst_req && !gd;
            end
            dn = (phase == 1 && ba && bd) || (phase == 2 && bd);
        end
        chk("inst_addr_ok", 64'(inst_addr_ok), 64'(gi));
        chk("data_addr_ok", 64'(data_addr_ok), 64'(gd));
        chk("inst_data_ok", 64'(inst_data_ok), 64'(dn && !m_owner));
        chk("data_data_ok", 64'(data_data_ok), 64'(dn && m_owner));
        if (dn && !(m_owner && m_wr))
            chk("rdata", 64'(m_owner ? data_rdata : inst_rdata), 64'(rd));
        if (!rst) begin
            chk("bus_req", 64'(bus_req), 64'(phase == 1));
            if (phase == 1) begin
                chk("bus_addr", 64'(bus_addr), 64'(m_addr));
                chk("bus_wr", 64'(bus_wr), 64'(m_wr));
                chk("bus_size", 64'(bus_size), 64'(m_size));
                if (m_wr) chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
            end
        end
        if (inst_addr_ok || data_addr_ok) begin
            g_cyc.push_back(cyc_n);
            g_own.push_back(data_addr_ok);
        end
        if (inst_data_ok || data_data_ok) begin
            d_cyc.push_back(cyc_n);
            d_own.push_back(data_data_ok);
            d_rd.push_back(data_data_ok ? data_rdata : inst_rdata);
        end
        if (bus_req) begin
            br_cyc.push_back(cyc_n);
            a_wr    = bus_wr;
            a_size  = bus_size;
            a_addr  = bus_addr;
            a_wdata = bus_wdata;
        end
        if (rst) begin
            phase  = 0;
            streak = 0;
        end else begin
            case (phase)
                0: begin
                    if (gd || gi) begin
                        if (gd) begin
                            m_owner = 1'b1;
                            m_wr    = data_wr;
                            m_size  = data_size;
                            m_addr  = data_addr;
                            m_wdata = data_wdata;
                            if (inst_req) streak = (streak < LIM) ? streak + 1 : LIM;
                            else streak = 0;
                        end else begin
                            m_owner = 1'b0;
                            m_wr    = 1'b0;
                            m_size  = 2'd2;
                            m_addr  = inst_addr;
                            streak  = 0;
                        end
                        phase    = 1;
                        ad_cnt   = (f_ad >= 0) ? f_ad : int'($urandom_range(0, 3));
                        same_cyc = (f_same >= 0) ? (f_same != 0) : ($urandom_range(0, 3) == 0);
                        wd_cnt   = (f_wd >= 0) ? f_wd : int'($urandom_range(0, 3));
                    end
                end
                1: begin
                    if (ba) phase = bd ? 0 : 2;
                    else ad_cnt--;
                end
                default: begin
                    if (bd) phase = 0;
                    else wd_cnt--;
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (gi) inst_req = 1'b0;
        if (gd) begin
            if (keep_data) data_addr = data_addr + 32'd4;
            else data_req = 1'b0;
        end
    endtask

    task automatic run_done(int n, int bound);
        int start;
        int k;
        start = d_cyc.size();
        k = 0;
        while (d_cyc.size() < start + n && k < bound) begin
            tick();
            k++;
        end
        chk("completion_timeout", 64'(d_cyc.size() >= start + n), 64'd1);
    endtask

    task automatic set_load(logic [31:0] a);
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = a;
        data_wdata = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int c0, k;
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0;
        data_addr = '0; data_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

        // reset state
        tick();
        tick();
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_wr", 64'(bus_wr), 64'd0);
        chk("rst_bus_size", 64'(bus_size), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        rst = 1'b0;
        tick();

        // lone fetch with fixed bus timing
        clear_logs();
        f_ad = 1; f_same = 0; f_wd = 1;
        f_rd_en = 1; f_rd = 32'h2402_0001;
        c0 = cyc_n;
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0000;
        run_done(1, 20);
        chk("fetch_grant_cyc", 64'(g_cyc[0] - c0), 64'd0);
        chk("fetch_breq_cnt", 64'(br_cyc.size()), 64'd2);
        chk("fetch_breq_first", 64'(br_cyc[0] - c0), 64'd1);
        chk("fetch_breq_last", 64'(br_cyc[1] - c0), 64'd2);
        chk("fetch_done_cyc", 64'(d_cyc[0] - c0), 64'd4);
        chk("fetch_done_own", 64'(d_own[0]), 64'd0);
        chk("fetch_rdata", 64'(d_rd[0]), 64'h2402_0001);
        set_load(32'h8000_0100);
        tick();
        chk("fetch_next_grant", 64'(g_cyc[1] - c0), 64'd5);
        run_done(1, 20);
        f_ad = -1; f_same = -1; f_wd = -1; f_rd_en = 0;

        // simultaneous requests: data first, inst after data completes
        clear_logs();
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0010;
        set_load(32'h8000_1000);
        run_done(2, 60);
        chk("simul_first_own", 64'(g_own[0]), 64'd1);
        chk("simul_second_own", 64'(g_own[1]), 64'd0);
        chk("simul_first_done", 64'(d_own[0]), 64'd1);
        chk("simul_inst_after", 64'(g_cyc[1] - d_cyc[0]), 64'd1);

        // starvation: 4 data grants, forced inst, then data again
        clear_logs();
        f_ad = 0; f_same = 1;
        keep_data = 1;
        set_load(32'h8000_2000);
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0020;
        k = 0;
        while (g_own.size() < 6 && k < 100) begin
            tick();
            k++;
        end
        keep_data = 0;
        data_req = 1'b0;
        chk("starve_grants", 64'(g_own.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("starve_own%0d", i), 64'(g_own[i]), 64'(i != 4));
        run_done(6 - d_cyc.size(), 20);
        f_ad = -1; f_same = -1;

        // byte store completing in the address cycle
        clear_logs();
        f_ad = 0; f_same = 1;
        data_req = 1'b1;
        data_wr = 1'b1;
        data_size = 2'd0;
        data_addr = 32'h8000_0003;
        data_wdata = 32'h0000_00A5;
        run_done(1, 10);
        chk("store_bus_wr", 64'(a_wr), 64'd1);
        chk("store_bus_size", 64'(a_size), 64'd0);
        chk("store_bus_addr", 64'(a_addr), 64'h8000_0003);
        chk("store_bus_wdata", 64'(a_wdata), 64'hA5);
        chk("store_done_own", 64'(d_own[0]), 64'd1);
        chk("store_no_wait", 64'(d_cyc[0] - g_cyc[0]), 64'd1);
        f_ad = -1; f_same = -1;

        // reset while waiting for data, stale response afterwards
        clear_logs();
        f_ad = 0; f_same = 0; f_wd = 6;
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0040;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        stale_bd = 1;
        tick();
        stale_bd = 0;
        chk("rstwait_no_ok", 64'(d_cyc.size()), 64'd0);
        chk("rstwait_bus_req", 64'(bus_req), 64'd0);
        f_ad = -1; f_same = -1; f_wd = -1;
        set_load(32'h8000_3000);
        run_done(1, 20);
        chk("rstwait_next_own", 64'(d_own[0]), 64'd1);

        // random traffic
        noise = 1;
        for (int i = 0; i < 800; i++) begin
            if (!inst_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    inst_req = 1'b1;
                    inst_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                inst_req = 1'b0;
            end
            if (!data_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    data_req = 1'b1;
                    data_wr = 1'($urandom_range(0, 1));
                    data_size = 2'($urandom_range(0, 2));
                    data_addr = $urandom;
                    data_wdata = $urandom;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                data_req = 1'b0;
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        noise = 0;
        inst_req = 1'b0;
        data_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
